id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter LOAD_BIT, default 0, index of the load flag in ctrl.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_RA, id_RB, id_WC  input  4 each  source A, source B, destination register addresses.
REQ-007 id_W_RB  input  1  decoded instruction writes WC.
REQ-008 id_opA, id_opB  input  DATA_W each  register-file read data.
REQ-009 id_ctrl  input  8  decoded execute controls; bit LOAD_BIT = load.
REQ-010 fwd_A, fwd_B  input  1 each  forward-select from forward unit for A/B.
REQ-011 fwd_data  input  DATA_W  result of instruction currently in EX.
REQ-012 stall_in  input  1  downstream hold request.
REQ-013 flush  input  1  kill the instruction entering EX (branch taken).
REQ-014 ex_valid  output  1  EX register holds a real instruction.
REQ-015 ex_RA, ex_RB, ex_WC  output  4 each  registered addresses.
REQ-016 ex_W_RB  output  1  registered write enable, forced 0 when ex_valid=0.
REQ-017 ex_opA, ex_opB  output  DATA_W each  registered operands after forwarding.
REQ-018 ex_ctrl  output  8  registered controls, forced 0 when ex_valid=0.
REQ-019 stall_out  output  1  upstream hold request (load-use), combinational.

Function
REQ-020 Per-edge priority SHALL be: rst > flush > stall_in > load-use bubble > advance.
REQ-021 Advance SHALL capture all id_* fields into ex_* with one-cycle latency; ex_valid <= id_valid.
REQ-022 On capture, ex_opA SHALL be fwd_data if fwd_A else id_opA; ex_opB likewise with fwd_B/id_opB.
REQ-023 Flush SHALL load a bubble: ex_valid=0, ex_W_RB=0, ex_ctrl=0; addresses/operands 0.
REQ-024 stall_in=1 (no flush) SHALL hold every ex_* register unchanged.
REQ-025 Load-use hazard = ex_valid & ex_ctrl[LOAD_BIT] & ex_W_RB & id_valid & (id_RA==ex_WC | id_RB==ex_WC).
REQ-026 FSM states IDLE, BUBBLE; reset state IDLE.
REQ-027 IDLE & hazard & !flush & !stall_in: stall_out=1, bubble loaded into EX, next state BUBBLE.
REQ-028 BUBBLE: stall_out=0, hazard ignored, normal advance, next state IDLE (unless stall_in: remain BUBBLE).
REQ-029 flush in any state SHALL force next state IDLE and stall_out=0.
REQ-030 stall_out SHALL be 0 whenever stall_in=1 (upstream already held).
REQ-031 Register r0 receives no special treatment; address equality only.

Reset
REQ-032 rst SHALL set ex_valid=0, ex_W_RB=0, ex_ctrl=0, all addresses/operands 0, state IDLE.
REQ-033 stall_out SHALL be 0 during and in the cycle after rst; rst mid-BUBBLE returns to IDLE.

Configuration
REQ-034 Macro LOAD_USE_STALL_EN defined: REQ-025..REQ-030 active.
REQ-035 Macro undefined: no FSM, stall_out tied 0, no bubble insertion; all other behaviour identical.

Verification
REQ-036 rst=1 two cycles, then id_valid=1, id_opA=16'h1234, fwd_A=0 -> next edge ex_valid=1, ex_opA=16'h1234.
REQ-037 id_opB=16'h0001, fwd_B=1, fwd_data=16'hBEEF -> ex_opB=16'hBEEF after one edge.
REQ-038 EX holds load WC=5, ex_W_RB=1; id_RA=5 -> stall_out=1 one cycle, ex_valid=0 next, then ID captured with stall_out=0.
REQ-039 stall_in=1 three cycles with changing id_* -> ex_* constant; flush=1 with stall_in=1 -> bubble.
REQ-040 Hazard present and flush=1 same cycle -> stall_out=0, bubble, state IDLE.
REQ-041 Build without LOAD_USE_STALL_EN, repeat REQ-038 stimulus -> stall_out=0, ID captured on first edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, flush and downstream hold.
// Optional load-use bubble insertion is enabled by defining LOAD_USE_STALL_EN.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOAD_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_RA,
    input  logic [3:0]        id_RB,
    input  logic [3:0]        id_WC,
    input  logic              id_W_RB,
    input  logic [DATA_W-1:0] id_opA,
    input  logic [DATA_W-1:0] id_opB,
    input  logic [7:0]        id_ctrl,
    input  logic              fwd_A,
    input  logic              fwd_B,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_RA,
    output logic [3:0]        ex_RB,
    output logic [3:0]        ex_WC,
    output logic              ex_W_RB,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [7:0]        ex_ctrl,
    output logic              stall_out
);

    logic load_use;

`ifdef LOAD_USE_STALL_EN
    typedef enum logic {IDLE, BUBBLE} state_t;

    state_t state, state_nxt;
    logic   hazard;

    assign hazard = ex_valid && ex_ctrl[LOAD_BIT] && ex_W_RB && id_valid &&
                    ((id_RA == ex_WC) || (id_RB == ex_WC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hazard && !stall_in) state_nxt = BUBBLE;
            BUBBLE:  if (!stall_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        stall_out = 1'b0;
        if (state == IDLE && hazard && !flush && !stall_in && !rst) begin
            stall_out = 1'b1;
        end
    end

    assign load_use = stall_out;
`else
    logic unused_load_flag;

    assign unused_load_flag = ex_ctrl[LOAD_BIT];
    assign stall_out        = 1'b0;
    assign load_use         = 1'b0;
`endif

    // Write enable and controls are qualified by id_valid so an empty slot never writes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid <= 1'b0;
            ex_RA    <= '0;
            ex_RB    <= '0;
            ex_WC    <= '0;
            ex_W_RB  <= 1'b0;
            ex_opA   <= '0;
            ex_opB   <= '0;
            ex_ctrl  <= '0;
        end else if (stall_in) begin
            ex_valid <= ex_valid;
        end else if (load_use) begin
            ex_valid <= 1'b0;
            ex_RA    <= '0;
            ex_RB    <= '0;
            ex_WC    <= '0;
            ex_W_RB  <= 1'b0;
            ex_opA   <= '0;
            ex_opB   <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_RA    <= id_RA;
            ex_RB    <= id_RB;
            ex_WC    <= id_WC;
            ex_W_RB  <= id_valid && id_W_RB;
            ex_opA   <= fwd_A ? fwd_data : id_opA;
            ex_opB   <= fwd_B ? fwd_data : id_opB;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural pipeline model.
// Follows LOAD_USE_STALL_EN the same way the design does.
module tb_id_ex_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned LB = 2;
`ifdef LOAD_USE_STALL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, id_valid, id_W_RB, fwd_A, fwd_B, stall_in, flush;
    logic [3:0]    id_RA, id_RB, id_WC;
    logic [DW-1:0] id_opA, id_opB, fwd_data;
    logic [7:0]    id_ctrl;
    logic          ex_valid, ex_W_RB, stall_out;
    logic [3:0]    ex_RA, ex_RB, ex_WC;
    logic [DW-1:0] ex_opA, ex_opB;
    logic [7:0]    ex_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.DATA_W(DW), .LOAD_BIT(LB)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_RA(id_RA), .id_RB(id_RB),
        .id_WC(id_WC), .id_W_RB(id_W_RB), .id_opA(id_opA), .id_opB(id_opB),
        .id_ctrl(id_ctrl), .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_data(fwd_data),
        .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_RA(ex_RA),
        .ex_RB(ex_RB), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_opA(ex_opA),
        .ex_opB(ex_opB), .ex_ctrl(ex_ctrl), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit [3:0]    ra, rb, wc;
        bit          w;
        bit [DW-1:0] a, b;
        bit [7:0]    ctrl;
    } slot_t;

    slot_t m;       // expected contents of the EX register
    bit    m_bub;   // previous accepted edge inserted a load-use bubble

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit haz;
        haz = m.v && m.ctrl[LB] && m.w && id_valid && (id_RA == m.wc || id_RB == m.wc);
        return EN && !rst && !flush && !stall_in && !m_bub && haz;
    endfunction

    task automatic model_edge();
        bit s;
        s = m_stall();
        if (rst || flush) begin
            m = '{default: '0};
            m_bub = 1'b0;
        end else if (stall_in) begin
            m = m;
        end else if (s) begin
            m = '{default: '0};
            m_bub = 1'b1;
        end else begin
            m.v    = id_valid;
            m.ra   = id_RA;
            m.rb   = id_RB;
            m.wc   = id_WC;
            m.w    = id_valid && id_W_RB;
            m.a    = fwd_A ? fwd_data : id_opA;
            m.b    = fwd_B ? fwd_data : id_opB;
            m.ctrl = id_valid ? id_ctrl : 8'h00;
            m_bub  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", ex_valid, m.v);
        check("ex_RA", ex_RA, m.ra);
        check("ex_RB", ex_RB, m.rb);
        check("ex_WC", ex_WC, m.wc);
        check("ex_W_RB", ex_W_RB, m.w);
        check("ex_opA", ex_opA, m.a);
        check("ex_opB", ex_opB, m.b);
        check("ex_ctrl", ex_ctrl, m.ctrl);
    endtask

    // Inputs are set after a falling edge; stall_out is checked before the rising edge.
    task automatic cycle();
        #1 check("stall_out", stall_out, m_stall());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        rst = 0; id_valid = 0; id_W_RB = 0; fwd_A = 0; fwd_B = 0; stall_in = 0; flush = 0;
        id_RA = 0; id_RB = 0; id_WC = 0; id_opA = 0; id_opB = 0; fwd_data = 0; id_ctrl = 0;
    endtask

    task automatic put_load_in_id(input logic [3:0] wc);
        clear_inputs();
        id_valid = 1; id_W_RB = 1; id_WC = wc; id_RA = 4'd1; id_RB = 4'd2;
        id_ctrl = 8'h00; id_ctrl[LB] = 1'b1; id_opA = 16'h0F0F;
    endtask

    initial begin
        m = '{default: '0};
        m_bub = 1'b0;
        clear_inputs();
        @(negedge clk);

        rst = 1;
        cycle();
        cycle();
        check("rst_valid", ex_valid, 1'b0);
        rst = 0;

        id_valid = 1; id_opA = 16'h1234; fwd_A = 0;
        cycle();
        check("r36_valid", ex_valid, 1'b1);
        check("r36_opA", ex_opA, 16'h1234);

        id_opB = 16'h0001; fwd_B = 1; fwd_data = 16'hBEEF;
        cycle();
        check("r37_opB", ex_opB, 16'hBEEF);

        put_load_in_id(4'd5);
        cycle();
        clear_inputs();
        id_valid = 1; id_RA = 4'd5; id_RB = 4'd9; id_WC = 4'd7; id_opA = 16'h00AA;
        #1 check("r38_stall", stall_out, EN);
        cycle();
        check("r38_valid_first", ex_valid, !EN);
        #1 check("r38_stall_after", stall_out, 1'b0);
        cycle();
        check("r38_valid_second", ex_valid, 1'b1);
        check("r38_opA", ex_opA, 16'h00AA);

        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            id_RA = 4'($urandom); id_opA = 16'($urandom); id_ctrl = 8'($urandom);
            cycle();
            check("r39_hold_opA", ex_opA, 16'h00AA);
        end
        flush = 1;
        cycle();
        check("r39_flush_valid", ex_valid, 1'b0);

        put_load_in_id(4'd3);
        cycle();
        clear_inputs();
        id_valid = 1; id_RB = 4'd3; flush = 1;
        #1 check("r40_stall", stall_out, 1'b0);
        cycle();
        check("r40_valid", ex_valid, 1'b0);

        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) < 3);
            flush    = ($urandom_range(0, 99) < 8);
            stall_in = ($urandom_range(0, 99) < 20);
            id_valid = ($urandom_range(0, 99) < 85);
            id_W_RB  = ($urandom_range(0, 99) < 75);
            id_RA    = 4'($urandom_range(0, 3));
            id_RB    = 4'($urandom_range(0, 3));
            id_WC    = 4'($urandom_range(0, 3));
            id_opA   = 16'($urandom);
            id_opB   = 16'($urandom);
            fwd_data = 16'($urandom);
            fwd_A    = 1'($urandom);
            fwd_B    = 1'($urandom);
            id_ctrl  = 8'($urandom);
            id_ctrl[LB] = ($urandom_range(0, 99) < 60);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
